// File: rtl/alu_issue_seq.sv
`timescale 1ns/1ps
// alu_issue_seq
// Command sequencer placed directly upstream of a 16-bit registered ALU.
// Commands are buffered in a small FIFO. Each one goes to the ALU as a
// one-cycle Enable pulse. The ALU's registered Results/CF are then
// captured, qualified per opcode, and returned over a response handshake.
//
// Ports
//   CLK, RST            clock (rising edge), synchronous active-high reset
//   cmd_valid/ready     command handshake; cmd_ready = FIFO not full
//   cmd_opcode/x/y      command payload
//   alu_enable          one-cycle issue pulse to the ALU
//   alu_opcode/x/y      operands held toward the ALU
//   alu_results/cf      registered ALU outputs
//   rsp_valid/ready     response handshake
//   rsp_result/cf/op    qualified response payload
//   busy                FSM not idle or FIFO non-empty
//   fifo_count          number of buffered commands
//   op_count            delivered responses, wraps modulo 2^CNT_W
module alu_issue_seq #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [2:0]                    cmd_opcode,
  input  logic [15:0]                   cmd_x,
  input  logic [15:0]                   cmd_y,
  output logic                          alu_enable,
  output logic [2:0]                    alu_opcode,
  output logic [15:0]                   alu_x,
  output logic [15:0]                   alu_y,
  input  logic [15:0]                   alu_results,
  input  logic                          alu_cf,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [15:0]                   rsp_result,
  output logic                          rsp_cf,
  output logic [2:0]                    rsp_opcode,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]              op_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = 35;  // {opcode, x, y}
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------- FIFO
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             fifo_empty, fifo_full;
  logic             push, pop;
  logic [ENT_W-1:0] head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);
  // Ready depends only on registered occupancy, never on a same-cycle pop.
  assign cmd_ready  = !fifo_full;
  assign push       = cmd_valid && !fifo_full;
  assign head       = mem_q[rd_ptr_q];

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_opcode, cmd_x, cmd_y};
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers are PTR_W wide, so they wrap at FIFO_DEPTH naturally.
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // ----------------------------------------------------------------- FSM
  logic capture;
  logic rsp_done;

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    capture  = 1'b0;
    rsp_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        capture = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_done = 1'b1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ------------------------------------------------------ ALU operand regs
  logic [2:0]  alu_opcode_q;
  logic [15:0] alu_x_q, alu_y_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      alu_opcode_q <= '0;
      alu_x_q      <= '0;
      alu_y_q      <= '0;
    end else if (pop) begin
      alu_opcode_q <= head[34:32];
      alu_x_q      <= head[31:16];
      alu_y_q      <= head[15:0];
    end
  end

  // ----------------------------------------------- result qualification
  // The ALU only drives CF for add (001/101) and compare (100); for the
  // logic ops CF is left stale and must be masked. NOP never samples the
  // ALU result at all.
  logic [15:0] qual_result;
  logic        qual_cf;

  always_comb begin
    qual_result = alu_results;
    qual_cf     = 1'b0;
    case (alu_opcode_q)
      3'b000: begin
        qual_result = '0;
        qual_cf     = 1'b0;
      end
      3'b001, 3'b101, 3'b100: begin
        qual_cf = alu_cf;
      end
      default: begin
        qual_cf = 1'b0;
      end
    endcase
  end

  logic [15:0]      rsp_result_q;
  logic             rsp_cf_q;
  logic [2:0]       rsp_opcode_q;
  logic [CNT_W-1:0] op_count_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rsp_result_q <= '0;
      rsp_cf_q     <= 1'b0;
      rsp_opcode_q <= '0;
      op_count_q   <= '0;
    end else begin
      if (capture) begin
        rsp_result_q <= qual_result;
        rsp_cf_q     <= qual_cf;
        rsp_opcode_q <= alu_opcode_q;
      end
      if (rsp_done) op_count_q <= op_count_q + CNT_W'(1);
    end
  end

  // ------------------------------------------------------------- outputs
  assign alu_enable = (state_q == S_ISSUE);
  assign alu_opcode = alu_opcode_q;
  assign alu_x      = alu_x_q;
  assign alu_y      = alu_y_q;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_result = rsp_result_q;
  assign rsp_cf     = rsp_cf_q;
  assign rsp_opcode = rsp_opcode_q;
  assign busy       = (state_q != S_IDLE) || !fifo_empty;
  assign fifo_count = count_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
`timescale 1ns/1ps
// Testbench for alu_issue_seq: directed steps plus a randomized phase,
// checked against a scoreboard of expected responses computed from X/Y.
module tb_alu_issue_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_opcode = '0;
  logic [15:0] cmd_x = '0;
  logic [15:0] cmd_y = '0;
  logic        alu_enable;
  logic [2:0]  alu_opcode;
  logic [15:0] alu_x, alu_y;
  logic [15:0] alu_results = '0;
  logic        alu_cf = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_result;
  logic        rsp_cf;
  logic [2:0]  rsp_opcode;
  logic        busy;
  logic [2:0]  fifo_count;
  logic [3:0]  op_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_issue_seq #(.FIFO_DEPTH(4), .CNT_W(4)) dut (
    .CLK(clk), .RST(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .alu_enable(alu_enable), .alu_opcode(alu_opcode),
    .alu_x(alu_x), .alu_y(alu_y),
    .alu_results(alu_results), .alu_cf(alu_cf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_cf(rsp_cf), .rsp_opcode(rsp_opcode),
    .busy(busy), .fifo_count(fifo_count), .op_count(op_count)
  );

  // Stand-in registered ALU: samples on Enable; CF only written by add and
  // compare, so it goes stale for the logic ops. NOP latches junk.
  always @(posedge clk) begin
    if (alu_enable) begin
      case (alu_opcode)
        3'b001, 3'b101: {alu_cf, alu_results} <= {1'b0, alu_x} + {1'b0, alu_y};
        3'b100: begin
          alu_results <= {15'd0, alu_x < alu_y};
          alu_cf      <= alu_x < alu_y;
        end
        3'b010: alu_results <= alu_x & alu_y;
        3'b011: alu_results <= alu_x | alu_y;
        3'b110: alu_results <= alu_x ^ alu_y;
        3'b111: alu_results <= ~alu_x;
        default: alu_results <= alu_x ^ alu_y ^ 16'hA5A5;
      endcase
    end
  end

  // Reference model: plain arithmetic from the opcode rules.
  function automatic logic [15:0] ref_res(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
    int sum;
    sum = int'(x) + int'(y);
    case (op)
      3'd0:       return 16'd0;
      3'd1, 3'd5: return 16'(sum % 65536);
      3'd4:       return (int'(x) < int'(y)) ? 16'd1 : 16'd0;
      3'd2:       return x & y;
      3'd3:       return x | y;
      3'd6:       return x ^ y;
      default:    return ~x;
    endcase
  endfunction

  function automatic logic ref_cf(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
    case (op)
      3'd1, 3'd5: return (int'(x) + int'(y)) > 65535;
      3'd4:       return int'(x) < int'(y);
      default:    return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] res;
    logic        cf;
  } exp_t;

  exp_t       exp_q[$];
  int         hs_times[$];
  logic [3:0] exp_ops = '0;
  int         cyc = 0;
  logic [15:0] last_result = '0;
  logic        last_cf = 1'b0;

  // Scoreboard monitor, sampling on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        exp_q.delete();
        exp_ops = '0;
      end else begin
        chk("op_count", 32'(op_count), 32'(exp_ops));
        if (cmd_valid && cmd_ready) begin
          exp_t e;
          e.op  = cmd_opcode;
          e.res = ref_res(cmd_opcode, cmd_x, cmd_y);
          e.cf  = ref_cf(cmd_opcode, cmd_x, cmd_y);
          exp_q.push_back(e);
        end
        if (rsp_valid && rsp_ready) begin
          hs_times.push_back(cyc);
          chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rsp_opcode", 32'(rsp_opcode), 32'(e.op));
            chk("rsp_result", 32'(rsp_result), 32'(e.res));
            chk("rsp_cf", 32'(rsp_cf), 32'(e.cf));
            $display("rsp op=%0d result=%04h cf=%0b", rsp_opcode, rsp_result, rsp_cf);
          end
          last_result = rsp_result;
          last_cf     = rsp_cf;
          exp_ops     = exp_ops + 4'd1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic push(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
    int w;
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_x      = x;
    cmd_y      = y;
    w = 0;
    while (!cmd_ready && w < 200) begin
      step();
      w++;
    end
    chk("push_wait_bound", 32'(w < 200), 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((busy || rsp_valid) && w < 500) begin
      step();
      w++;
    end
    chk("drain_bound", 32'(w < 500), 32'd1);
  endtask

  initial begin
    int lat;
    int en_cnt;
    int w;
    int seen;
    int sent;
    logic acc;

    // Reset state
    do_reset();
    chk("rst_alu_enable", 32'(alu_enable), 32'd0);
    chk("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    chk("rst_alu_x", 32'(alu_x), 32'd0);
    chk("rst_alu_y", 32'(alu_y), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_result", 32'(rsp_result), 32'd0);
    chk("rst_rsp_cf", 32'(rsp_cf), 32'd0);
    chk("rst_rsp_opcode", 32'(rsp_opcode), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);

    // 1: single ADD, latency and enable pulse width
    rsp_ready = 1'b1;
    push(3'b001, 16'hFFFF, 16'h0002);
    lat = 0;
    en_cnt = 0;
    while (!rsp_valid && lat < 20) begin
      step();
      lat++;
      if (alu_enable) en_cnt++;
    end
    chk("add_latency", 32'(lat), 32'd3);
    chk("add_enable_cycles", 32'(en_cnt), 32'd1);
    chk("add_rsp_result", 32'(rsp_result), 32'h0001);
    chk("add_rsp_cf", 32'(rsp_cf), 32'd1);
    step();
    chk("add_enable_after", 32'(alu_enable), 32'd0);
    drain();
    chk("add_op_count", 32'(op_count), 32'd1);

    // 2: compare then AND; AND must mask the stale CF left by compare
    push(3'b100, 16'd5, 16'd9);
    push(3'b010, 16'hF0F0, 16'h0FF0);
    drain();
    chk("and_result", 32'(last_result), 32'h00F0);
    chk("and_cf", 32'(last_cf), 32'd0);
    chk("cmp_and_op_count", 32'(op_count), 32'd3);

    // 3: back-pressure fill, then release and check 3-cycle spacing
    do_reset();
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(3'(i + 1), 16'(16'h1000 * i + 16'hFF00), 16'(i + 300));
    cmd_valid  = 1'b1;
    cmd_opcode = 3'b011;
    cmd_x      = 16'h00FF;
    cmd_y      = 16'hFF00;
    step();
    step();
    chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("full_fifo_count", 32'(fifo_count), 32'd4);
    chk("full_rsp_valid", 32'(rsp_valid), 32'd1);
    hs_times.delete();
    rsp_ready = 1'b1;
    w = 0;
    while (!cmd_ready && w < 50) begin
      step();
      w++;
    end
    step();
    cmd_valid = 1'b0;
    w = 0;
    while (hs_times.size() < 6 && w < 100) begin
      step();
      w++;
    end
    chk("release_rsp_count", 32'(hs_times.size()), 32'd6);
    for (int i = 1; i < hs_times.size(); i++)
      chk("release_gap", 32'(hs_times[i] - hs_times[i-1]), 32'd3);
    drain();
    chk("release_op_count", 32'(op_count), 32'd6);

    // 4: NOP issues operands but returns zero
    push(3'b000, 16'h1234, 16'h5678);
    w = 0;
    while (!alu_enable && w < 20) begin
      step();
      w++;
    end
    chk("nop_alu_enable", 32'(alu_enable), 32'd1);
    chk("nop_alu_x", 32'(alu_x), 32'h1234);
    chk("nop_alu_y", 32'(alu_y), 32'h5678);
    chk("nop_alu_opcode", 32'(alu_opcode), 32'd0);
    drain();
    chk("nop_result", 32'(last_result), 32'd0);
    chk("nop_cf", 32'(last_cf), 32'd0);

    // 5: reset in CAPTURE with two commands queued
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_opcode = 3'b001; cmd_x = 16'd10; cmd_y = 16'd20;
    step();
    cmd_opcode = 3'b010; cmd_x = 16'd3;  cmd_y = 16'd6;
    step();
    chk("midrst_issue", 32'(alu_enable), 32'd1);
    cmd_opcode = 3'b110; cmd_x = 16'd7;  cmd_y = 16'd1;
    step();
    cmd_valid = 1'b0;
    chk("midrst_queued", 32'(fifo_count), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_fifo_count", 32'(fifo_count), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_op_count", 32'(op_count), 32'd0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (rsp_valid) seen++;
    end
    chk("midrst_no_rsp", 32'(seen), 32'd0);

    // 6: op_count wraps at 2^4
    for (int i = 0; i < 17; i++)
      push(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
    drain();
    chk("wrap_op_count", 32'(op_count), 32'd1);

    // Randomized traffic with random back-pressure
    sent = 0;
    for (int c = 0; c < 1500 && sent < 60; c++) begin
      if (!cmd_valid && $urandom_range(0, 2) != 0) begin
        cmd_valid  = 1'b1;
        cmd_opcode = 3'($urandom_range(0, 7));
        cmd_x      = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
        cmd_y      = 16'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      acc = cmd_valid && cmd_ready;
      step();
      if (acc) begin
        cmd_valid = 1'b0;
        sent++;
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    chk("random_sent", 32'(sent), 32'd60);
    drain();
    chk("random_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
